// File: rtl/unary_drv_pkg.sv
// Shared types and sizing helpers for the unary-adder operand driver.
package unary_drv_pkg;

    typedef enum logic [2:0] {IDLE, SEND, TURN, COLLECT, HOLD} state_e;

    localparam int STREAM_LEN_DEF = 15;

    function automatic int width_for(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/unary_thermo_counter.sv
// Saturating ones counter for a unary stream; flags any 1 that follows a 0.
module unary_thermo_counter #(
    parameter int RES_W = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [RES_W-1:0] sum,
    output logic             err
);

    logic [RES_W-1:0] sum_q, sum_d;
    logic             zero_seen_q, zero_seen_d;
    logic             err_q, err_d;

    always_comb begin
        sum_d       = sum_q;
        zero_seen_d = zero_seen_q;
        err_d       = err_q;
        if (en) begin
            if (din) begin
                if (sum_q != {RES_W{1'b1}}) begin
                    sum_d = sum_q + RES_W'(1);
                end
                if (zero_seen_q) begin
                    err_d = 1'b1;
                end
            end else begin
                zero_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sum_q       <= '0;
            zero_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            zero_seen_q <= zero_seen_d;
            err_q       <= err_d;
        end
    end

    assign sum = sum_q;
    assign err = err_q;

endmodule

// File: rtl/unary_operand_driver.sv
// Serialises two operands as thermometer streams, then collects and counts the adder result.
// Optional self-check of the collected sum is built when UNARY_DRV_CHECK_EN is defined.
module unary_operand_driver
    import unary_drv_pkg::*;
#(
    parameter int STREAM_LEN = STREAM_LEN_DEF,
    parameter int CNT_W      = width_for(STREAM_LEN),
    parameter int RES_W      = CNT_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [CNT_W-1:0] op_a,
    input  logic [CNT_W-1:0] op_b,
    output logic             A,
    output logic             B,
    output logic             en,
    output logic             read_or_write,
    input  logic             dout,
    input  logic             C,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_sum,
    output logic             res_ovf,
    output logic             res_err,
    output logic             res_clamp,
    output logic             res_mismatch
);

    localparam int               COLLECT_LEN = 2 * STREAM_LEN;
    localparam int               IDX_W       = width_for(COLLECT_LEN);
    localparam logic [CNT_W-1:0] MAX_OP      = CNT_W'(STREAM_LEN);
    localparam logic [IDX_W-1:0] SEND_LAST   = IDX_W'(STREAM_LEN - 1);
    localparam logic [IDX_W-1:0] COLL_LAST   = IDX_W'(COLLECT_LEN - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] a_q, a_d, b_q, b_d;
    logic             op_ready_q, op_ready_d;
    logic             a_out_q, a_out_d, b_out_q, b_out_d;
    logic             en_q, en_d, rw_q, rw_d;
    logic             res_valid_q, res_valid_d;
    logic             ovf_q, ovf_d, clamp_q, clamp_d;
    logic             coll_q, coll_d;
    logic             accept;

    always_comb begin
        accept  = op_valid & op_ready_q;
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        ovf_d   = ovf_q;
        clamp_d = clamp_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    idx_d   = '0;
                    a_d     = (op_a > MAX_OP) ? MAX_OP : op_a;
                    b_d     = (op_b > MAX_OP) ? MAX_OP : op_b;
                    clamp_d = (op_a > MAX_OP) | (op_b > MAX_OP);
                    ovf_d   = 1'b0;
                end
            end
            SEND: begin
                if (idx_q == SEND_LAST) begin
                    state_d = TURN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            TURN: begin
                state_d = COLLECT;
                idx_d   = '0;
            end
            COLLECT: begin
                if (idx_q == COLL_LAST) begin
                    state_d = HOLD;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            HOLD: begin
                if (res_valid_q & res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stream outputs trail the state register by one edge; coll_q marks cycles the adder drives dout.
        if (coll_q & C) begin
            ovf_d = 1'b1;
        end
        op_ready_d  = (state_d == IDLE);
        res_valid_d = (state_q == HOLD) && (state_d == HOLD);
        en_d        = (state_q == SEND) || (state_q == TURN) || (state_q == COLLECT);
        rw_d        = (state_q == TURN) || (state_q == COLLECT);
        a_out_d     = (state_q == SEND) && (32'(idx_q) < 32'(a_q));
        b_out_d     = (state_q == SEND) && (32'(idx_q) < 32'(b_q));
        coll_d      = (state_q == COLLECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            op_ready_q  <= 1'b0;
            a_out_q     <= 1'b0;
            b_out_q     <= 1'b0;
            en_q        <= 1'b0;
            rw_q        <= 1'b0;
            res_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            clamp_q     <= 1'b0;
            coll_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_ready_q  <= op_ready_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            en_q        <= en_d;
            rw_q        <= rw_d;
            res_valid_q <= res_valid_d;
            ovf_q       <= ovf_d;
            clamp_q     <= clamp_d;
            coll_q      <= coll_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    logic [RES_W-1:0] cnt_sum;
    logic             cnt_err;

    unary_thermo_counter #(.RES_W(RES_W)) u_cnt (
        .clk (clk),
        .clr (rst | accept),
        .en  (coll_q),
        .din (dout),
        .sum (cnt_sum),
        .err (cnt_err)
    );

`ifdef UNARY_DRV_CHECK_EN
    logic             mm_q, mm_d;
    logic [RES_W-1:0] final_sum;

    // The last dout sample lands on the same edge res_valid rises, so fold it in here.
    always_comb begin
        final_sum = cnt_sum;
        if (coll_q && dout && (cnt_sum != {RES_W{1'b1}})) begin
            final_sum = cnt_sum + RES_W'(1);
        end
        mm_d = mm_q;
        if (accept) begin
            mm_d = 1'b0;
        end else if ((state_q == HOLD) && !res_valid_q) begin
            mm_d = (final_sum != (RES_W'(a_q) + RES_W'(b_q)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mm_q <= 1'b0;
        end else begin
            mm_q <= mm_d;
        end
    end

    assign res_mismatch = mm_q;
`else
    assign res_mismatch = 1'b0;
`endif

    assign op_ready      = op_ready_q;
    assign A             = a_out_q;
    assign B             = b_out_q;
    assign en            = en_q;
    assign read_or_write = rw_q;
    assign res_valid     = res_valid_q;
    assign res_sum       = cnt_sum;
    assign res_ovf       = ovf_q;
    assign res_err       = cnt_err;
    assign res_clamp     = clamp_q;

endmodule

// File: tb/tb_unary_operand_driver.sv
// Randomised and directed bench for unary_operand_driver against a stream-level reference model.
module tb_unary_operand_driver;

    localparam int SL    = 15;
    localparam int CW    = 5;
    localparam int RW    = CW + 1;
    localparam int CL    = 2 * SL;
    localparam int LAT   = SL + 1 + CL + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_valid;
    logic          op_ready;
    logic [CW-1:0] op_a, op_b;
    logic          A, B, en, read_or_write;
    logic          dout, C;
    logic          res_valid, res_ready;
    logic [RW-1:0] res_sum;
    logic          res_ovf, res_err, res_clamp, res_mismatch;

    int total = 0;
    int bad   = 0;

    unary_operand_driver #(.STREAM_LEN(SL), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .A             (A),
        .B             (B),
        .en            (en),
        .read_or_write (read_or_write),
        .dout          (dout),
        .C             (C),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_sum       (res_sum),
        .res_ovf       (res_ovf),
        .res_err       (res_err),
        .res_clamp     (res_clamp),
        .res_mismatch  (res_mismatch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (op_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("op_ready_wait", {31'd0, op_ready}, 32'd1);
    endtask

    // One full operation: the adder side replays dpat/cpat on the COLLECT window.
    task automatic run_op(input int x, input int y, input logic [CL-1:0] dpat,
                          input logic [CL-1:0] cpat, input int hold);
        int          ca, cb, lat, en_cnt, rw_cnt, n_ones, h;
        logic        busy_ready, zero_seen, exp_err, exp_ovf, exp_mm, stable;
        logic [SL-1:0] av, bv;
        logic [31:0] exp_sum;
        ca = (x > SL) ? SL : x;
        cb = (y > SL) ? SL : y;
        n_ones = 0;
        zero_seen = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i < CL; i++) begin
            if (dpat[i]) begin
                n_ones++;
                if (zero_seen) exp_err = 1'b1;
            end else begin
                zero_seen = 1'b1;
            end
        end
        exp_sum = (n_ones > (2 ** RW) - 1) ? (2 ** RW) - 1 : n_ones;
        exp_ovf = |cpat;
`ifdef UNARY_DRV_CHECK_EN
        exp_mm = (exp_sum != 32'(ca + cb));
`else
        exp_mm = 1'b0;
`endif

        wait_ready();
        op_valid = 1'b1;
        op_a = CW'(x);
        op_b = CW'(y);
        @(negedge clk);
        op_valid = 1'b0;
        chk("ready_drop", {31'd0, op_ready}, 32'd0);

        av = '0; bv = '0; en_cnt = 0; rw_cnt = 0; lat = 0; busy_ready = 1'b0;
        for (int e = 1; e <= 100 && lat == 0; e++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                lat = e;
            end else begin
                if (e <= SL) begin
                    av[e-1] = A;
                    bv[e-1] = B;
                end
                en_cnt += int'(en);
                rw_cnt += int'(read_or_write);
                busy_ready |= op_ready;
            end
            dout = (e >= LAT - CL && e < LAT) ? dpat[e-(LAT-CL)] : 1'b0;
            C    = (e >= LAT - CL && e < LAT) ? cpat[e-(LAT-CL)] : 1'b0;
            op_valid  = (e == 5);
            if (e == 5) op_a = CW'($urandom);
            res_ready = (e == 10);
        end
        dout = 1'b0;
        C = 1'b0;

        chk("latency", 32'(lat), 32'(LAT));
        chk("stream_a", 32'(av), 32'((32'h1 << ca) - 1));
        chk("stream_b", 32'(bv), 32'((32'h1 << cb) - 1));
        chk("en_cycles", 32'(en_cnt), 32'(SL + 1 + CL));
        chk("rw_cycles", 32'(rw_cnt), 32'(1 + CL));
        chk("busy_ready", {31'd0, busy_ready}, 32'd0);
        chk("res_sum", 32'(res_sum), exp_sum);
        chk("res_flags", {28'd0, res_ovf, res_err, res_clamp, res_mismatch},
            {28'd0, exp_ovf, exp_err, (x > SL) || (y > SL), exp_mm});
        chk("hold_bus", {29'd0, en, read_or_write, op_ready}, 32'd0);

        stable = 1'b1;
        for (h = 0; h < hold; h++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || 32'(res_sum) !== exp_sum || res_ovf !== exp_ovf ||
                res_err !== exp_err || op_ready !== 1'b0) stable = 1'b0;
        end
        chk("hold_stable", {31'd0, stable}, 32'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("release", {30'd0, res_valid, op_ready}, 32'd1);
    endtask

    logic [CL-1:0] dp, cp;
    int            rx, ry, rn;

    initial begin
        rst = 1'b1;
        op_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        dout = 1'b0;
        C = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {16'd0, op_ready, A, B, en, read_or_write, res_valid, res_sum,
            res_ovf, res_err, res_clamp, res_mismatch}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, op_ready}, 32'd1);

        run_op(11, 1, CL'((32'h1 << 12) - 1), '0, 2);
        run_op(0, 0, '0, '0, 0);
        run_op(15, 15, CL'((32'h1 << 30) - 1), CL'(32'h1 << 10), 1);
        run_op(20, 3, CL'((32'h1 << 18) - 1), '0, 1);
        run_op(6, 2, CL'(32'b1011), '0, 5);

        // Abort during the third COLLECT cycle.
        wait_ready();
        op_valid = 1'b1;
        op_a = 5'd7;
        op_b = 5'd5;
        @(negedge clk);
        op_valid = 1'b0;
        for (int e = 1; e <= LAT - CL + 2; e++) begin
            @(negedge clk);
            dout = (e >= LAT - CL);
        end
        rst = 1'b1;
        @(negedge clk);
        dout = 1'b0;
        chk("abort_outputs", {25'd0, en, read_or_write, res_valid, op_ready, A, B, res_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'd0, op_ready}, 32'd1);
        chk("abort_sum", 32'(res_sum), 32'd0);

        for (int t = 0; t < 20; t++) begin
            rx = $urandom_range(0, 31);
            ry = $urandom_range(0, 31);
            rn = ((rx > SL) ? SL : rx) + ((ry > SL) ? SL : ry);
            if ($urandom_range(0, 1) == 0) dp = CL'((32'h1 << rn) - 1);
            else                           dp = CL'($urandom);
            cp = ($urandom_range(0, 3) == 0) ? CL'(32'h1 << $urandom_range(0, CL - 1)) : '0;
            run_op(rx, ry, dp, cp, $urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
